sand_ram_write_arbiter: RTL and testbench

//  Merges two write streams into the single write port of the game-state RAM.
//  - Stream 1 comes from the game-state controller (cell updates). It cannot stall and always has priority.
//  - Stream 2 comes from the mouse pixel drawer (user sand). It is buffered in a FIFO and drains on idle RAM cycles.

---
 rtl/sand_pkg.sv | 24 ++
 rtl/sand_req_fifo.sv | 74 +++++++
 rtl/sand_ram_write_arbiter.sv | 118 +++++++++++
 tb/tb_sand_ram_write_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sand_pkg.sv
// Shared types for the sand RAM write arbiter: write request record, arbiter states
// and default widths for the 640x480 single-bit game-state RAM.
package sand_pkg;

  localparam int SAND_ADDR_W  = 19;
  localparam int SAND_DATA_W  = 1;
  localparam int SAND_FIFO_D  = 8;

  typedef struct packed {
    logic [SAND_ADDR_W-1:0] addr;
    logic [SAND_DATA_W-1:0] data;
  } ram_wr_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GST   = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  function automatic int sand_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sand_req_fifo.sv
// Synchronous request FIFO with flush; head data is combinational.
// DEPTH must be a power of two so the pointers wrap on their own width.
module sand_req_fifo
  import sand_pkg::*;
#(
  parameter int  DEPTH = SAND_FIFO_D,
  parameter type req_t = ram_wr_req_t
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         push_i,
  input  req_t                         wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output req_t                         rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  req_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // flush wins over both push and pop so nothing survives a screen clear
  assign do_push = push_i && !full_o  && !flush_i;
  assign do_pop  = pop_i  && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sand_ram_write_arbiter.sv
// Merges game-state updates (priority, never stall) and buffered user draws into one
// registered RAM write port. Optional counters under SAND_ARB_STATS_EN.
module sand_ram_write_arbiter
  import sand_pkg::*;
#(
  parameter int ADDR_WIDTH = SAND_ADDR_W,
  parameter int DATA_WIDTH = SAND_DATA_W,
  parameter int FIFO_DEPTH = SAND_FIFO_D
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          gst_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]         gst_wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         gst_wr_data_i,
  input  logic                          draw_valid_i,
  input  logic [ADDR_WIDTH-1:0]         draw_addr_i,
  input  logic [DATA_WIDTH-1:0]         draw_data_i,
  output logic                          draw_ready_o,
  input  logic                          flush_i,
  output logic                          ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0]         ram_wr_data_o,
`ifdef SAND_ARB_STATS_EN
  output logic [15:0]                   stall_cnt_o,
  output logic [15:0]                   starve_cnt_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } arb_req_t;

  arb_state_t state_q, state_d;
  arb_req_t   wr_q, wr_d, head;
  logic       rdy_en_q;
  logic       fifo_full, fifo_empty, push, pop;

  // keeps ready low through reset and until the first clock after release
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rdy_en_q <= 1'b0;
    else            rdy_en_q <= 1'b1;
  end

  assign draw_ready_o = rdy_en_q && !fifo_full && !flush_i;
  assign push         = draw_valid_i && draw_ready_o;

  sand_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .req_t (arb_req_t)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .wdata_i   ({draw_addr_i, draw_data_i}),
    .pop_i     (pop),
    .flush_i   (flush_i),
    .rdata_o   (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count_o)
  );

  // state_q names the source of the write currently on the RAM port
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ARB_IDLE;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = ARB_IDLE;
    if (gst_wr_en_i)                  state_d = ARB_GST;
    else if (!fifo_empty && !flush_i) state_d = ARB_DRAIN;
  end

  always_comb begin
    pop  = 1'b0;
    wr_d = '0;
    case (state_d)
      ARB_GST:   wr_d = {gst_wr_addr_i, gst_wr_data_i};
      ARB_DRAIN: begin
        pop  = 1'b1;
        wr_d = head;
      end
      default:   wr_d = '0;
    endcase
  end

  assign ram_wr_en_o   = (state_q != ARB_IDLE);
  assign ram_wr_addr_o = wr_q.addr;
  assign ram_wr_data_o = wr_q.data;

`ifdef SAND_ARB_STATS_EN
  logic [15:0] stall_q, starve_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      if (draw_valid_i && !draw_ready_o && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (!fifo_empty && gst_wr_en_i && starve_q != 16'hFFFF)
        starve_q <= starve_q + 16'd1;
    end
  end

  assign stall_cnt_o  = stall_q;
  assign starve_cnt_o = starve_q;
`endif

endmodule

// File: tb/tb_sand_ram_write_arbiter.sv
// Bench for sand_ram_write_arbiter: table-driven vectors plus hand sequences, with a
// behavioural queue model feeding a per-cycle expected-write scoreboard.
module tb_sand_ram_write_arbiter;

  localparam int AW    = 19;
  localparam int DW    = 1;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b1;
  logic          gst_wr_en_i = 1'b0;
  logic [AW-1:0] gst_wr_addr_i = '0;
  logic [DW-1:0] gst_wr_data_i = '0;
  logic          draw_valid_i = 1'b0;
  logic [AW-1:0] draw_addr_i = '0;
  logic [DW-1:0] draw_data_i = '0;
  logic          draw_ready_o;
  logic          flush_i = 1'b0;
  logic          ram_wr_en_o;
  logic [AW-1:0] ram_wr_addr_o;
  logic [DW-1:0] ram_wr_data_o;
  logic [$clog2(DEPTH):0] fifo_count_o;
`ifdef SAND_ARB_STATS_EN
  logic [15:0]   stall_cnt_o, starve_cnt_o;
`endif

  always #5 clk = ~clk;

  sand_ram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .gst_wr_en_i   (gst_wr_en_i),
    .gst_wr_addr_i (gst_wr_addr_i),
    .gst_wr_data_i (gst_wr_data_i),
    .draw_valid_i  (draw_valid_i),
    .draw_addr_i   (draw_addr_i),
    .draw_data_i   (draw_data_i),
    .draw_ready_o  (draw_ready_o),
    .flush_i       (flush_i),
    .ram_wr_en_o   (ram_wr_en_o),
    .ram_wr_addr_o (ram_wr_addr_o),
    .ram_wr_data_o (ram_wr_data_o),
`ifdef SAND_ARB_STATS_EN
    .stall_cnt_o   (stall_cnt_o),
    .starve_cnt_o  (starve_cnt_o),
`endif
    .fifo_count_o  (fifo_count_o)
  );

  typedef struct packed { logic en; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } dq_t;
  typedef struct packed {
    logic ge; logic [AW-1:0] ga; logic [DW-1:0] gd;
    logic dv; logic [AW-1:0] da; logic [DW-1:0] dd;
    logic fl; logic [7:0] cnt;
  } vec_t;

  wr_t sb[$];   // expected RAM port contents, one entry per cycle
  dq_t mq[$];   // model of buffered draws
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Entered at posedge+1; drives one cycle, returns at the next posedge+1.
  task automatic step(input logic ge, input logic [AW-1:0] ga, input logic [DW-1:0] gd,
                      input logic dv, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                      input logic fl, output logic acc);
    logic er;
    wr_t  e, got;
    dq_t  h;
    gst_wr_en_i = ge; gst_wr_addr_i = ga; gst_wr_data_i = gd;
    draw_valid_i = dv; draw_addr_i = da; draw_data_i = dd; flush_i = fl;
    er = (mq.size() < DEPTH) && !fl;
    e  = '0;
    if (ge) e = {1'b1, ga, gd};
    else if (mq.size() > 0 && !fl) begin
      h = mq.pop_front();
      e = {1'b1, h.addr, h.data};
    end
    if (fl) mq.delete();
    if (dv && er) mq.push_back({da, dd});
    sb.push_back(e);
    @(negedge clk);
    chk("draw_ready", 32'(draw_ready_o), 32'(er));
    acc = dv && draw_ready_o;
    @(posedge clk); #1;
    got = sb.pop_front();
    chk("ram_wr_en", 32'(ram_wr_en_o), 32'(got.en));
    if (got.en) begin
      chk("ram_wr_addr", 32'(ram_wr_addr_o), 32'(got.addr));
      chk("ram_wr_data", 32'(ram_wr_data_o), 32'(got.data));
    end
    chk("fifo_count", 32'(fifo_count_o), 32'(mq.size()));
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, a);
  endtask

  task automatic do_reset();
    gst_wr_en_i = 1'b0; draw_valid_i = 1'b0; flush_i = 1'b0;
    reset_n_i = 1'b0;
    mq.delete(); sb.delete();
    #2;
    chk("rst_wr_en", 32'(ram_wr_en_o), 32'd0);
    chk("rst_addr",  32'(ram_wr_addr_o), 32'd0);
    chk("rst_ready", 32'(draw_ready_o), 32'd0);
    chk("rst_count", 32'(fifo_count_o), 32'd0);
    @(negedge clk);
    reset_n_i = 1'b1;
    #1 chk("ready_before_clk", 32'(draw_ready_o), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_clk", 32'(draw_ready_o), 32'd1);
    chk("count_after_rel", 32'(fifo_count_o), 32'd0);
    chk("wr_en_after_rel", 32'(ram_wr_en_o), 32'd0);
  endtask

  vec_t vt[13];

  initial begin
    logic a;
    int   acc_n;

    // ge ga gd dv da dd fl cnt
    vt[0]  = '{1'b0, 19'h0,     1'b0, 1'b1, 19'h00100, 1'b1, 1'b0, 8'd1};
    vt[1]  = '{1'b0, 19'h0,     1'b0, 1'b0, 19'h0,     1'b0, 1'b0, 8'd0};
    vt[2]  = '{1'b0, 19'h0,     1'b0, 1'b0, 19'h0,     1'b0, 1'b0, 8'd0};
    vt[3]  = '{1'b1, 19'h00200, 1'b0, 1'b1, 19'h00200, 1'b1, 1'b0, 8'd1};
    vt[4]  = '{1'b0, 19'h0,     1'b0, 1'b0, 19'h0,     1'b0, 1'b0, 8'd0};
    vt[5]  = '{1'b0, 19'h0,     1'b0, 1'b0, 19'h0,     1'b0, 1'b0, 8'd0};
    vt[6]  = '{1'b1, 19'h00003, 1'b1, 1'b0, 19'h0,     1'b0, 1'b0, 8'd0};
    vt[7]  = '{1'b0, 19'h0,     1'b0, 1'b1, 19'h00011, 1'b1, 1'b0, 8'd1};
    vt[8]  = '{1'b1, 19'h00005, 1'b1, 1'b1, 19'h00012, 1'b0, 1'b0, 8'd2};
    vt[9]  = '{1'b0, 19'h0,     1'b0, 1'b1, 19'h00013, 1'b1, 1'b0, 8'd2};
    vt[10] = '{1'b0, 19'h0,     1'b0, 1'b0, 19'h0,     1'b0, 1'b0, 8'd1};
    vt[11] = '{1'b0, 19'h0,     1'b0, 1'b0, 19'h0,     1'b0, 1'b0, 8'd0};
    vt[12] = '{1'b0, 19'h7FFFF, 1'b1, 1'b1, 19'h7FFFF, 1'b1, 1'b0, 8'd1};

    #1;
    do_reset();
`ifdef SAND_ARB_STATS_EN
    chk("stall_rst",  32'(stall_cnt_o), 32'd0);
    chk("starve_rst", 32'(starve_cnt_o), 32'd0);
`endif

    // table: single draw latency, same-address GST/draw ordering, push+pop together
    for (int i = 0; i < 13; i++) begin
      step(vt[i].ge, vt[i].ga, vt[i].gd, vt[i].dv, vt[i].da, vt[i].dd, vt[i].fl, a);
      chk($sformatf("tbl_count[%0d]", i), 32'(fifo_count_o), 32'(vt[i].cnt));
    end
    idle(3);

    // GST every cycle for 12 cycles with draws pushing each cycle
    do_reset();
    acc_n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 19'h01000 + 19'(i), 1'(i), 1'b1, 19'h02000 + 19'(i), 1'b1, 1'b0, a);
      if (a) acc_n++;
    end
    chk("sat_accepted", 32'(acc_n), 32'd8);
    idle(10);
`ifdef SAND_ARB_STATS_EN
    chk("stall_cnt",  32'(stall_cnt_o), 32'd4);
    chk("starve_cnt", 32'(starve_cnt_o), 32'd11);
`endif

    // 5 queued draws then flush together with a draw_valid
    for (int i = 0; i < 5; i++)
      step(1'b1, 19'h03000 + 19'(i), 1'b0, 1'b1, 19'h04000 + 19'(i), 1'b1, 1'b0, a);
    chk("pre_flush_count", 32'(fifo_count_o), 32'd5);
    step(1'b0, '0, '0, 1'b1, 19'h05555, 1'b1, 1'b1, a);
    chk("flush_not_accepted", 32'(a), 32'd0);
    chk("flush_count", 32'(fifo_count_o), 32'd0);
    idle(4);

    // flush with a concurrent GST write: GST still lands
    for (int i = 0; i < 2; i++)
      step(1'b0, '0, '0, 1'b1, 19'h06000 + 19'(i), 1'b0, 1'b0, a);
    step(1'b1, 19'h06100, 1'b1, 1'b1, 19'h06200, 1'b1, 1'b1, a);
    idle(3);

    // reset mid-drain with 3 queued
    for (int i = 0; i < 3; i++)
      step(1'b1, 19'h07000 + 19'(i), 1'b1, 1'b1, 19'h08000 + 19'(i), 1'b1, 1'b0, a);
    idle(1);
    #2 reset_n_i = 1'b0;
    mq.delete(); sb.delete();
    #1;
    chk("midrst_wr_en", 32'(ram_wr_en_o), 32'd0);
    chk("midrst_count", 32'(fifo_count_o), 32'd0);
    @(negedge clk);
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
